cpu_sequencer: RTL
==================

# cpu_sequencer

Run-control and program-counter sequencer for the CSCv2 datapath. It owns the 8-bit PC and the latched NZVC flags that together address the top ROM. It consumes the ROM's PCincr bit, a jump target and the ALU flags, and issues an execute strobe that qualifies the ROM's Aload, Bload and RAMwrite outputs. It adds run, single-step, self-jump halt and an instruction counter. An optional PC breakpoint is selected by `SEQ_BREAKPOINT_EN`.

## Interface
- PC_WIDTH, 8, PC and jump-target width; must equal the top ROM's PC address bits.
- FLAG_WIDTH, 4, width of the NZVC flags.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- run  in  1  level; high requests free-running execution.
- step  in  1  single-cycle pulse; requests execution of exactly one instruction while stopped.
- pcincr  in  1  top ROM PCincr bit: 1 selects PC+1, 0 selects jaddr.
- jaddr  in  PC_WIDTH  jump target (instruction operand).
- flag_load  in  1  1 latches alu_flags on an executing edge.
- alu_flags  in  FLAG_WIDTH  NZVC produced by the ALU this cycle.
- bp_en  in  1  breakpoint enable; ignored without the macro.
- bp_addr  in  PC_WIDTH  breakpoint PC; ignored without the macro.
- pc  out  PC_WIDTH  registered PC; drives ROM address [7:0].
- nzvc  out  FLAG_WIDTH  registered flags; drives ROM address [11:8].
- exec  out  1  combinational, 1 when the current cycle executes; the datapath ANDs it into Aload, Bload and RAMwrite.
- halted  out  1  registered, 1 in HALT.
- stopped  out  1  registered, 1 in IDLE.
- instret  out  CNT_WIDTH  count of executed instructions; wraps modulo 2^CNT_WIDTH.

## Operation
States: IDLE, RUN, STEP, HALT.
- exec = (state==RUN) or (state==STEP).
- next_pc = pcincr ? pc+1 : jaddr. pc+1 is modulo 2^PC_WIDTH, so 0xFF goes to 0x00.

On every edge with exec=1:
- pc ← next_pc.
- nzvc ← alu_flags if flag_load; otherwise nzvc holds.
- instret ← instret+1.

With exec=0, pc, nzvc and instret hold.

A self-jump is pcincr=0 and jaddr==pc.

Transitions, evaluated in priority order within each state:
- IDLE: run=1 goes to RUN. Otherwise step=1 goes to STEP. Otherwise stay in IDLE.
- RUN: self-jump goes to HALT. Otherwise run=0 goes to IDLE. Otherwise a breakpoint hit goes to IDLE. Otherwise stay in RUN.
- STEP: self-jump goes to HALT. Otherwise go to IDLE. step is ignored outside IDLE.
- HALT: sticky, with exec=0; left only by reset. The self-jump edge itself still executes: pc is reloaded with the same value, flags may load, and instret increments.

Reset (reset_n=0 at an edge, taking priority over everything):
- state=IDLE, pc=0, nzvc=0, instret=0.
- halted=0, stopped=1, so exec=0.
- A reset in any state, including mid-RUN, aborts with no partial update; the datapath sees exec=0 from the next cycle.

## Timing
- exec is a pure function of the registered state; it carries no input-to-output combinational path.
- run rising in IDLE: the first executing cycle is the cycle after the edge.
- run falling in RUN: the edge that samples run=0 still executes, because exec was already 1 in that cycle; the state is IDLE afterwards.
- step: exactly one executing cycle, starting one cycle after the edge that samples it.
- Simultaneous run=1 and step=1 in IDLE: run wins.
- halted and stopped are valid the cycle after the transition.

## Configuration
`SEQ_BREAKPOINT_EN`:
- **Defined:** in RUN, an executing edge with bp_en=1 and next_pc==bp_addr goes to IDLE. pc then equals bp_addr and that instruction has not been executed.
  - STEP never breaks.
  - A run issued while pc==bp_addr executes that instruction first and therefore does not re-break on it.
  - A self-jump takes priority over a breakpoint hit.
- **Undefined:** the compare logic is absent, bp_en and bp_addr are unused, and RUN leaves only via run=0 or a self-jump.

## Structure
- Shared package cpu_pkg holds:
  - the seq_state_t enum (IDLE, RUN, STEP, HALT);
  - PC_W=8 and FLAG_W=4, shared with the top ROM wrapper.
- No sub-module is warranted; the next-PC mux, FSM and counter live in one module.

## Test plan
- Reset, then run=1 with pcincr=1 for 300 cycles: pc counts 0x00→0xFF→0x00→…, instret=300, exec stays 1 throughout.
- In IDLE at pc=0x10, pulse step with pcincr=0 and jaddr=0x40: pc=0x40, instret+1, exactly one cycle has exec=1, and stopped returns to 1.
- flag_load=1 with alu_flags=0xA on one step, then flag_load=0 with alu_flags=0x5 on the next: nzvc=0xA after both.
- In RUN, present pc=0x22 with pcincr=0 and jaddr=0x22: halted=1 and exec=0 afterwards; pulsing step and run changes nothing until reset_n=0, after which pc=0, nzvc=0, instret=0.
- With `SEQ_BREAKPOINT_EN`, bp_en=1 and bp_addr=0x05, run from 0: the state stops at IDLE with pc=0x05 and instret=5. Re-asserting run gives pc 0x06, 0x07… with no immediate re-break. Without the macro, the same stimulus runs through 0x05.
- reset_n=0 asserted mid-RUN at pc=0x80 together with run=1: the next cycle shows pc=0, stopped=1 and exec=0. After release with run still 1, execution resumes from 0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and widths for the CSCv2 run-control sequencer and the top ROM wrapper.
package cpu_pkg;

  localparam int PC_W   = 8;
  localparam int FLAG_W = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } seq_state_t;

  // An instruction retires in every cycle spent in RUN or STEP.
  function automatic logic state_executes(input seq_state_t s);
    return (s == RUN) || (s == STEP);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Run-control / program-counter sequencer: PC, NZVC latch, run/step/halt FSM, retired counter.
// Optional PC breakpoint compiled in with SEQ_BREAKPOINT_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH   = PC_W,
  parameter int FLAG_WIDTH = FLAG_W,
  parameter int CNT_WIDTH  = CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  step,
  input  logic                  pcincr,
  input  logic [PC_WIDTH-1:0]   jaddr,
  input  logic                  flag_load,
  input  logic [FLAG_WIDTH-1:0] alu_flags,
  input  logic                  bp_en,
  input  logic [PC_WIDTH-1:0]   bp_addr,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [FLAG_WIDTH-1:0] nzvc,
  output logic                  exec,
  output logic                  halted,
  output logic                  stopped,
  output logic [CNT_WIDTH-1:0]  instret
);

  seq_state_t          state;
  logic [PC_WIDTH-1:0] next_pc;
  logic                self_jump;
  logic                bp_hit;

  assign exec = state_executes(state);

  // Next-PC mux and self-jump (halt) detection.
  always_comb begin
    if (pcincr) begin
      next_pc = pc + PC_WIDTH'(1);
    end else begin
      next_pc = jaddr;
    end
    self_jump = (!pcincr) && (jaddr == pc);
  end

`ifdef SEQ_BREAKPOINT_EN
  // Compare the address about to be loaded, so a run started on bp_addr executes it first.
  always_comb begin
    if (bp_en) begin
      bp_hit = (next_pc == bp_addr);
    end else begin
      bp_hit = 1'b0;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr};
  assign bp_hit    = 1'b0;
`endif

  // Run-control FSM with registered status flags, PC, flags and retired counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc      <= {PC_WIDTH{1'b0}};
      nzvc    <= {FLAG_WIDTH{1'b0}};
      instret <= {CNT_WIDTH{1'b0}};
      halted  <= 1'b0;
      stopped <= 1'b1;
    end else begin
      if (exec) begin
        pc      <= next_pc;
        instret <= instret + CNT_WIDTH'(1);
        if (flag_load) begin
          nzvc <= alu_flags;
        end
      end

      case (state)
        IDLE: begin
          if (run) begin
            state   <= RUN;
            stopped <= 1'b0;
          end else if (step) begin
            state   <= STEP;
            stopped <= 1'b0;
          end else begin
            state   <= IDLE;
            stopped <= 1'b1;
          end
          halted <= 1'b0;
        end
        RUN: begin
          if (self_jump) begin
            state   <= HALT;
            halted  <= 1'b1;
            stopped <= 1'b0;
          end else if (!run || bp_hit) begin
            state   <= IDLE;
            halted  <= 1'b0;
            stopped <= 1'b1;
          end else begin
            state   <= RUN;
            halted  <= 1'b0;
            stopped <= 1'b0;
          end
        end
        STEP: begin
          if (self_jump) begin
            state   <= HALT;
            halted  <= 1'b1;
            stopped <= 1'b0;
          end else begin
            state   <= IDLE;
            halted  <= 1'b0;
            stopped <= 1'b1;
          end
        end
        HALT: begin
          state   <= HALT;
          halted  <= 1'b1;
          stopped <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          halted  <= 1'b0;
          stopped <= 1'b1;
        end
      endcase
    end
  end

endmodule
